flag_ctrl: RTL and testbench
============================

# flag_ctrl

Sequencer and owner of the CPU status flags (Carry, Zero, Borrow). It accepts flag-affecting instructions from the decoder and waits for the ALU result. It then commits only the flags selected by the instruction's update mask. It also keeps a small LIFO of saved flag sets for CALL/interrupt entry and return, and evaluates branch conditions for the program counter logic.

## Interface
- `TIMEOUT`, default 8: maximum cycles in WAIT_ALU before the operation is abandoned (≥1).
- `STK_DEPTH`, default 4: flag save-stack entries (power of 2, ≥2).
- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `op_valid` in 1: decoder presents a flag-affecting instruction.
- `op_ready` out 1: `state==IDLE && !save_req && !restore_req`.
- `op_upd` in 3: update mask `{B,Z,C}`.
- `op_clr` in 1: clear-all-flags instruction. `op_upd` is ignored.
- `alu_done` in 1: ALU result valid this cycle.
- `alu_c`, `alu_z`, `alu_b` in 1: ALU flag results, sampled with `alu_done`.
- `save_req` in 1: single-cycle pulse, push `{B,Z,C}`.
- `restore_req` in 1: single-cycle pulse, pop into flags.
- `err_clr` in 1: clears the sticky error bits.
- `cond_sel` in 2: 00 C, 01 Z, 10 B, 11 always.
- `cond_inv` in 1: inverts the selected condition.
- `cond_true` out 1: combinational branch decision from the current flag outputs.
- `flag_c`, `flag_z`, `flag_b` out 1: registered flags.
- `busy` out 1: `state==WAIT_ALU`.
- `stk_ovf`, `stk_unf`, `seq_err`, `tmo_err` out 1: sticky error bits.

## Operation
- States are IDLE and WAIT_ALU. Reset enters IDLE.
- IDLE, handshake `op_valid && op_ready`:
  - With `op_clr`: all flags clear at that edge. State stays IDLE.
  - Otherwise: `op_upd` is latched into the mask register, the timeout counter is zeroed, and the state moves to WAIT_ALU.
- WAIT_ALU:
  - On `alu_done`: for each mask bit set, the corresponding flag takes its ALU value. Unmasked flags hold. State returns to IDLE.
  - Without `alu_done`: the counter increments. When the counter reaches `TIMEOUT-1` with no `alu_done`, the state returns to IDLE, flags are unchanged and `tmo_err` is set.
  - If `alu_done` arrives on the final-count cycle, the commit wins and `tmo_err` is not set.
- `alu_done` in IDLE is ignored.
- Save/restore is handled only in IDLE and takes priority over the op handshake.
  - `save_req`: pushes `{flag_b,flag_z,flag_c}`. When the stack is full, nothing is pushed and `stk_ovf` is set.
  - `restore_req`: pops into all three flags. When the stack is empty, flags hold and `stk_unf` is set.
  - Both asserted in the same cycle: neither is performed and `seq_err` is set.
  - Either asserted in WAIT_ALU: the request is ignored and `seq_err` is set.
- `cond_true = (cond_sel==3) ? ~cond_inv : sel_flag ^ cond_inv`.
- `err_clr` clears the four sticky bits. A new error in the same cycle wins (the bit stays set).

## Timing
- Reset values:
  - All flags 0 and all error bits 0.
  - Stack pointer 0 (empty), `busy` 0.
  - `op_ready` is 1 whenever `save_req` and `restore_req` are low.
- An op accepted at edge N commits at the edge of the first cycle M > N with `alu_done`. `op_ready` is high again in cycle M+1.
- Minimum op occupancy is 2 cycles. The op throughput limit is 1 per 2 cycles.
- A clear op takes effect at the accept edge. A back-to-back op can be accepted the next cycle.
- A push or pop updates the flags/stack at the request edge. The stack is visible to a request in the next cycle.
- Asserting `rst_n` low mid-WAIT_ALU aborts immediately: flags clear, the stack empties, and a late `alu_done` is ignored.
- `cond_true` has zero latency relative to the flag registers.

## Structure
- Package `flag_pkg` holds:
  - the state encoding;
  - the `cond_sel` codes;
  - flag bit indices (C=0, Z=1, B=2).
- Sub-module `flag_stack` is a `STK_DEPTH`×3 LIFO with `push`, `pop`, `full`, `empty` and `dout`. Its pointer has width `$clog2(STK_DEPTH)+1`.
- `flag_ctrl` holds the FSM, the mask register, the timeout counter, the flag registers, the error bits and the condition mux.

## Test plan
- Reset, then an op with `op_upd`=3'b011 and `alu_done` 2 cycles later with c=1, z=1, b=1 → flags C=1, Z=1, B=0, and `op_ready` returns the cycle after commit.
- Set all flags, then a clear op → all flags 0 one edge later, and `busy` never asserts.
- Accept an op and hold `alu_done` low with `TIMEOUT`=8 → IDLE after 8 WAIT cycles, flags unchanged, `tmo_err`=1. Then `err_clr` → `tmo_err`=0.
- Push 5 times with `STK_DEPTH`=4 and distinct flags → `stk_ovf`=1. Pop 4 times → flags come back in LIFO order. A 5th pop → `stk_unf`=1 and flags hold.
- `save_req`+`restore_req` together in IDLE → `seq_err`=1 and stack unchanged. `save_req` during WAIT_ALU → `seq_err`=1 and no push.
- Sweep `cond_sel` 0–3 × `cond_inv` over all 8 flag combinations → `cond_true` matches the reference function every cycle.

Source files
------------

// File: rtl/flag_pkg.sv
// flag_pkg: shared types and constants for the CPU status-flag controller.
//   state_t : controller FSM states
//   cond_t  : branch-condition select codes (cond_sel)
//   FLAG_*  : bit positions of C/Z/B inside a packed {B,Z,C} flag vector
package flag_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    COND_C      = 2'b00,
    COND_Z      = 2'b01,
    COND_B      = 2'b10,
    COND_ALWAYS = 2'b11
  } cond_t;

  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_B = 2;
  localparam int NFLAGS = 3;

endpackage

// File: rtl/flag_stack.sv
// flag_stack: DEPTH x W LIFO holding saved flag sets.
//   clk, rst_n : clock, async active-low reset (empties the stack)
//   push, din  : write din on top; ignored when full
//   pop        : discard the top entry; ignored when empty
//   dout       : current top entry (valid when !empty)
//   full/empty : occupancy status
module flag_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] ptr;
  logic [AW-1:0] top_idx;

  assign full    = (ptr == PW'(DEPTH));
  assign empty   = (ptr == '0);
  assign top_idx = ptr[AW-1:0] - AW'(1);
  assign dout    = mem[top_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (push && !full) begin
      ptr <= ptr + PW'(1);
    end else if (pop && !empty) begin
      ptr <= ptr - PW'(1);
    end
  end

  // NOTE: the storage array has no reset; an entry is only ever read after
  // it was written, because the pointer (which is reset) guards every access.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[ptr[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/flag_ctrl.sv
// flag_ctrl: sequencer and owner of the Carry/Zero/Borrow status flags.
//   op_valid/op_ready/op_upd/op_clr : flag-affecting instruction handshake
//   alu_done, alu_c/z/b             : ALU flag results
//   save_req/restore_req            : push/pop flags on the save stack
//   err_clr                         : clears sticky error bits
//   cond_sel/cond_inv/cond_true     : branch-condition evaluation
//   flag_c/z/b                      : registered flags
//   busy                            : waiting for the ALU
//   stk_ovf/stk_unf/seq_err/tmo_err : sticky error bits
import flag_pkg::*;

module flag_ctrl #(
  parameter int TIMEOUT   = 8,
  parameter int STK_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       op_valid,
  output logic       op_ready,
  input  logic [2:0] op_upd,
  input  logic       op_clr,
  input  logic       alu_done,
  input  logic       alu_c,
  input  logic       alu_z,
  input  logic       alu_b,
  input  logic       save_req,
  input  logic       restore_req,
  input  logic       err_clr,
  input  logic [1:0] cond_sel,
  input  logic       cond_inv,
  output logic       cond_true,
  output logic       flag_c,
  output logic       flag_z,
  output logic       flag_b,
  output logic       busy,
  output logic       stk_ovf,
  output logic       stk_unf,
  output logic       seq_err,
  output logic       tmo_err
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t             state;
  logic [NFLAGS-1:0]  flags;
  logic [NFLAGS-1:0]  mask;
  logic [CNT_W-1:0]   cnt;
  logic [NFLAGS-1:0]  alu_flags;
  logic [NFLAGS-1:0]  stk_dout;
  logic               stk_full, stk_empty;

  logic in_idle, req_one_save, req_one_restore;
  logic do_push, do_pop;
  logic ovf_evt, unf_evt, seq_evt, tmo_evt;

  assign alu_flags = {alu_b, alu_z, alu_c};
  assign in_idle   = (state == ST_IDLE);
  assign busy      = (state == ST_WAIT);
  assign op_ready  = in_idle && !save_req && !restore_req;

  // A lone request is serviced only in IDLE; a simultaneous pair, or any
  // request while the ALU is outstanding, is a sequencing error.
  assign req_one_save    = save_req && !restore_req;
  assign req_one_restore = restore_req && !save_req;
  assign do_push = in_idle && req_one_save && !stk_full;
  assign do_pop  = in_idle && req_one_restore && !stk_empty;
  assign ovf_evt = in_idle && req_one_save && stk_full;
  assign unf_evt = in_idle && req_one_restore && stk_empty;
  assign seq_evt = (save_req || restore_req) && (!in_idle || (save_req && restore_req));
  // alu_done on the final count commits instead of timing out.
  assign tmo_evt = busy && !alu_done && (cnt == CNT_LAST);

  flag_stack #(
    .DEPTH (STK_DEPTH),
    .W     (NFLAGS)
  ) u_stack (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (do_push),
    .pop   (do_pop),
    .din   (flags),
    .dout  (stk_dout),
    .full  (stk_full),
    .empty (stk_empty)
  );

  // NOTE: all state here is sequential and uses non-blocking assignments so
  // every register sees the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      flags <= '0;
      mask  <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (do_pop) begin
            flags <= stk_dout;
          end else if (op_valid && op_ready) begin
            if (op_clr) begin
              flags <= '0;
            end else begin
              mask  <= op_upd;
              cnt   <= '0;
              state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (alu_done) begin
            flags <= (flags & ~mask) | (alu_flags & mask);
            state <= ST_IDLE;
          end else if (cnt == CNT_LAST) begin
            state <= ST_IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Sticky errors: a new event in the same cycle as err_clr keeps the bit set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stk_ovf <= 1'b0;
      stk_unf <= 1'b0;
      seq_err <= 1'b0;
      tmo_err <= 1'b0;
    end else begin
      stk_ovf <= ovf_evt || (stk_ovf && !err_clr);
      stk_unf <= unf_evt || (stk_unf && !err_clr);
      seq_err <= seq_evt || (seq_err && !err_clr);
      tmo_err <= tmo_evt || (tmo_err && !err_clr);
    end
  end

  assign flag_c = flags[FLAG_C];
  assign flag_z = flags[FLAG_Z];
  assign flag_b = flags[FLAG_B];

  // NOTE: sel_flag gets a default before the case so no latch is inferred.
  logic sel_flag;
  always_comb begin
    sel_flag = 1'b0;
    case (cond_t'(cond_sel))
      COND_C:  sel_flag = flags[FLAG_C];
      COND_Z:  sel_flag = flags[FLAG_Z];
      COND_B:  sel_flag = flags[FLAG_B];
      default: sel_flag = 1'b0;
    endcase
  end

  assign cond_true = (cond_t'(cond_sel) == COND_ALWAYS) ? !cond_inv : (sel_flag ^ cond_inv);

endmodule

// File: tb/tb_flag_ctrl.sv
// tb_flag_ctrl: directed self-checking bench for flag_ctrl (TIMEOUT=8,
// STK_DEPTH=4). Inputs change 1 ns after a rising edge; outputs are sampled
// at that same point, i.e. away from the active edge.
module tb_flag_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       op_valid, op_ready, op_clr;
  logic [2:0] op_upd;
  logic       alu_done, alu_c, alu_z, alu_b;
  logic       save_req, restore_req, err_clr;
  logic [1:0] cond_sel;
  logic       cond_inv, cond_true;
  logic       flag_c, flag_z, flag_b, busy;
  logic       stk_ovf, stk_unf, seq_err, tmo_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  flag_ctrl #(.TIMEOUT(8), .STK_DEPTH(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .op_valid    (op_valid),
    .op_ready    (op_ready),
    .op_upd      (op_upd),
    .op_clr      (op_clr),
    .alu_done    (alu_done),
    .alu_c       (alu_c),
    .alu_z       (alu_z),
    .alu_b       (alu_b),
    .save_req    (save_req),
    .restore_req (restore_req),
    .err_clr     (err_clr),
    .cond_sel    (cond_sel),
    .cond_inv    (cond_inv),
    .cond_true   (cond_true),
    .flag_c      (flag_c),
    .flag_z      (flag_z),
    .flag_b      (flag_b),
    .busy        (busy),
    .stk_ovf     (stk_ovf),
    .stk_unf     (stk_unf),
    .seq_err     (seq_err),
    .tmo_err     (tmo_err)
  );

  wire [2:0] flags = {flag_b, flag_z, flag_c};
  wire [3:0] errs  = {stk_ovf, stk_unf, seq_err, tmo_err};

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Load all three flags through a full-mask op committed one cycle later.
  task automatic set_flags(input logic [2:0] v);
    op_valid = 1'b1; op_clr = 1'b0; op_upd = 3'b111;
    step();
    op_valid = 1'b0;
    alu_done = 1'b1; {alu_b, alu_z, alu_c} = v;
    step();
    alu_done = 1'b0; {alu_b, alu_z, alu_c} = 3'b000;
    check("set_flags", {5'd0, flags}, {5'd0, v});
  endtask

  task automatic do_save();
    save_req = 1'b1; step(); save_req = 1'b0;
  endtask

  task automatic do_restore();
    restore_req = 1'b1; step(); restore_req = 1'b0;
  endtask

  task automatic do_err_clr();
    err_clr = 1'b1; step(); err_clr = 1'b0;
  endtask

  function automatic logic ref_cond(input logic [2:0] f, input logic [1:0] s, input logic inv);
    if (s == 2'd3) return !inv;
    return f[s] ^ inv;
  endfunction

  initial begin
    rst_n = 1'b0;
    op_valid = 0; op_clr = 0; op_upd = 0; alu_done = 0; alu_c = 0; alu_z = 0; alu_b = 0;
    save_req = 0; restore_req = 0; err_clr = 0; cond_sel = 0; cond_inv = 0;

    // ---- reset state
    #12;
    check("rst_flags", {5'd0, flags}, 8'h00);
    check("rst_errs", {4'd0, errs}, 8'h00);
    check("rst_busy", {7'd0, busy}, 8'h00);
    check("rst_ready", {7'd0, op_ready}, 8'h01);
    save_req = 1'b1; #1;
    check("ready_low_on_save", {7'd0, op_ready}, 8'h00);
    save_req = 1'b0;
    rst_n = 1'b1;
    step();

    // ---- masked op: upd=011, alu_done two cycles after accept
    op_valid = 1'b1; op_upd = 3'b011;
    step();
    op_valid = 1'b0;
    check("op_busy", {7'd0, busy}, 8'h01);
    check("op_not_ready", {7'd0, op_ready}, 8'h00);
    step();
    check("op_still_busy", {7'd0, busy}, 8'h01);
    alu_done = 1'b1; {alu_b, alu_z, alu_c} = 3'b111;
    step();
    alu_done = 1'b0; {alu_b, alu_z, alu_c} = 3'b000;
    check("masked_commit", {5'd0, flags}, 8'h03);
    check("ready_after_commit", {7'd0, op_ready}, 8'h01);
    check("idle_after_commit", {7'd0, busy}, 8'h00);

    // ---- clear op, then a back-to-back op next cycle
    set_flags(3'b111);
    op_valid = 1'b1; op_clr = 1'b1; op_upd = 3'b111;
    step();
    check("clear_flags", {5'd0, flags}, 8'h00);
    check("clear_no_busy", {7'd0, busy}, 8'h00);
    op_clr = 1'b0; op_upd = 3'b001;
    step();
    op_valid = 1'b0;
    check("b2b_accept", {7'd0, busy}, 8'h01);
    alu_done = 1'b1; {alu_b, alu_z, alu_c} = 3'b111;
    step();
    alu_done = 1'b0; {alu_b, alu_z, alu_c} = 3'b000;
    check("b2b_commit_c_only", {5'd0, flags}, 8'h01);

    // ---- alu_done while IDLE is ignored
    alu_done = 1'b1; {alu_b, alu_z, alu_c} = 3'b110;
    step();
    alu_done = 1'b0; {alu_b, alu_z, alu_c} = 3'b000;
    check("idle_alu_ignored", {5'd0, flags}, 8'h01);

    // ---- timeout: 8 WAIT cycles without alu_done
    op_valid = 1'b1; op_upd = 3'b111;
    step();
    op_valid = 1'b0;
    for (int i = 1; i <= 7; i++) step();
    check("tmo_wait7_busy", {7'd0, busy}, 8'h01);
    check("tmo_wait7_noerr", {7'd0, tmo_err}, 8'h00);
    step();
    check("tmo_idle", {7'd0, busy}, 8'h00);
    check("tmo_err_set", {7'd0, tmo_err}, 8'h01);
    check("tmo_flags_hold", {5'd0, flags}, 8'h01);
    do_err_clr();
    check("tmo_err_cleared", {7'd0, tmo_err}, 8'h00);

    // ---- alu_done on the final count: commit wins
    op_valid = 1'b1; op_upd = 3'b110;
    step();
    op_valid = 1'b0;
    for (int i = 1; i <= 7; i++) step();
    alu_done = 1'b1; {alu_b, alu_z, alu_c} = 3'b100;
    step();
    alu_done = 1'b0; {alu_b, alu_z, alu_c} = 3'b000;
    check("final_cnt_commit", {5'd0, flags}, 8'h05);
    check("final_cnt_no_tmo", {7'd0, tmo_err}, 8'h00);

    // ---- stack: 4 pushes fill it, the 5th overflows
    set_flags(3'b001); do_save();
    set_flags(3'b010); do_save();
    set_flags(3'b011); do_save();
    set_flags(3'b100); do_save();
    check("no_ovf_at_4", {7'd0, stk_ovf}, 8'h00);
    set_flags(3'b101); do_save();
    check("ovf_set", {7'd0, stk_ovf}, 8'h01);
    check("push_keeps_flags", {5'd0, flags}, 8'h05);
    do_restore(); check("pop1", {5'd0, flags}, 8'h04);
    do_restore(); check("pop2", {5'd0, flags}, 8'h03);
    do_restore(); check("pop3", {5'd0, flags}, 8'h02);
    do_restore(); check("pop4", {5'd0, flags}, 8'h01);
    check("no_unf_yet", {7'd0, stk_unf}, 8'h00);
    do_restore();
    check("unf_set", {7'd0, stk_unf}, 8'h01);
    check("unf_flags_hold", {5'd0, flags}, 8'h01);
    do_err_clr();
    check("errs_cleared", {4'd0, errs}, 8'h00);

    // ---- save+restore together: seq_err, stack untouched
    do_save();                        // stack holds {001}
    set_flags(3'b110);
    save_req = 1'b1; restore_req = 1'b1;
    step();
    save_req = 1'b0; restore_req = 1'b0;
    check("both_seq_err", {7'd0, seq_err}, 8'h01);
    check("both_flags_hold", {5'd0, flags}, 8'h06);
    do_restore();
    check("both_stack_intact", {5'd0, flags}, 8'h01);
    check("both_no_unf", {7'd0, stk_unf}, 8'h00);
    do_restore();
    check("both_single_entry", {7'd0, stk_unf}, 8'h01);

    // err_clr with a new error in the same cycle: error wins
    err_clr = 1'b1; save_req = 1'b1; restore_req = 1'b1;
    step();
    err_clr = 1'b0; save_req = 1'b0; restore_req = 1'b0;
    check("clr_vs_new_seq", {7'd0, seq_err}, 8'h01);
    check("clr_unf_cleared", {7'd0, stk_unf}, 8'h00);
    do_err_clr();

    // ---- save during WAIT_ALU: seq_err, no push
    op_valid = 1'b1; op_upd = 3'b111;
    step();
    op_valid = 1'b0;
    save_req = 1'b1;
    step();
    save_req = 1'b0;
    check("wait_save_seq_err", {7'd0, seq_err}, 8'h01);
    check("wait_save_busy", {7'd0, busy}, 8'h01);
    alu_done = 1'b1; {alu_b, alu_z, alu_c} = 3'b010;
    step();
    alu_done = 1'b0; {alu_b, alu_z, alu_c} = 3'b000;
    check("wait_save_commit", {5'd0, flags}, 8'h02);
    do_restore();
    check("wait_save_no_push", {7'd0, stk_unf}, 8'h01);
    do_err_clr();

    // ---- condition sweep over all flag combinations
    for (int v = 0; v < 8; v++) begin
      set_flags(3'(v));
      for (int s = 0; s < 4; s++) begin
        for (int inv = 0; inv < 2; inv++) begin
          cond_sel = 2'(s); cond_inv = 1'(inv);
          #1;
          check($sformatf("cond_f%0d_s%0d_i%0d", v, s, inv), {7'd0, cond_true},
                {7'd0, ref_cond(3'(v), 2'(s), 1'(inv))});
        end
      end
    end
    cond_sel = 2'd0; cond_inv = 1'b0;

    // ---- reset in the middle of WAIT_ALU
    set_flags(3'b011);
    do_save();
    op_valid = 1'b1; op_upd = 3'b111;
    step();
    op_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("midrst_flags", {5'd0, flags}, 8'h00);
    check("midrst_busy", {7'd0, busy}, 8'h00);
    alu_done = 1'b1; {alu_b, alu_z, alu_c} = 3'b111;
    #2 rst_n = 1'b1;
    step();
    alu_done = 1'b0; {alu_b, alu_z, alu_c} = 3'b000;
    check("midrst_late_alu", {5'd0, flags}, 8'h00);
    do_restore();
    check("midrst_stack_empty", {7'd0, stk_unf}, 8'h01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

endmodule
